// File: rtl/ram_dma_pkg.sv
// Shared definitions for the RAM burst DMA engine: state encoding and
// default field widths.
package ram_dma_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

endpackage

// File: rtl/ram_burst_dma_if.sv
// Command, stream and RAM-pin bundle for ram_burst_dma. Signal names keep
// the engine's point of view: i_* are engine inputs, o_* engine outputs.
// The slave modport is the engine; master is whoever drives commands,
// streams and hosts the RAM.
interface ram_burst_dma_if
    import ram_dma_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) ();

    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic                  i_cmd_write;
    logic [ADDR_WIDTH-1:0] i_cmd_addr;
    logic [LEN_WIDTH-1:0]  i_cmd_len;

    logic                  i_wr_valid;
    logic                  o_wr_ready;
    logic [DATA_WIDTH-1:0] i_wr_data;

    logic                  o_rd_valid;
    logic                  i_rd_ready;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_rd_last;

    logic                  o_ram_we;
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic [DATA_WIDTH-1:0] o_ram_data;
    logic [DATA_WIDTH-1:0] i_ram_data;

    logic                  o_busy;
    logic                  o_done;

    modport slave (
        input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
        input  i_wr_valid, i_wr_data,
        input  i_rd_ready,
        input  i_ram_data,
        output o_cmd_ready, o_wr_ready,
        output o_rd_valid, o_rd_data, o_rd_last,
        output o_ram_we, o_ram_addr, o_ram_data,
        output o_busy, o_done
    );

    modport master (
        output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
        output i_wr_valid, i_wr_data,
        output i_rd_ready,
        output i_ram_data,
        input  o_cmd_ready, o_wr_ready,
        input  o_rd_valid, o_rd_data, o_rd_last,
        input  o_ram_we, o_ram_addr, o_ram_data,
        input  o_busy, o_done
    );

endinterface

// File: rtl/ram_burst_dma.sv
// Burst engine in front of a single-port RAM (sync write, comb read).
// One command at a time: stream a burst into sequential addresses, or
// stream sequential addresses out through a one-deep output register.
module ram_burst_dma
    import ram_dma_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
    input  logic            i_clk,
    input  logic            i_rst,
    ram_burst_dma_if.slave  bus
);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  fetch_pending;
    logic                  rd_valid;
    logic                  rd_last;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  done;

    logic cmd_accept;
    logic wr_accept;
    logic rd_load;
    logic rd_take;
    logic last_count;

    assign last_count = (remaining == '0);
    assign cmd_accept = (state == ST_IDLE) && bus.i_cmd_valid;
    assign wr_accept  = (state == ST_WRITE) && bus.i_wr_valid;
    // The output register refills whenever it is empty or being drained,
    // which keeps one word per cycle flowing under continuous ready.
    assign rd_load    = (state == ST_READ) && fetch_pending && (!rd_valid || bus.i_rd_ready);
    assign rd_take    = (state == ST_READ) && rd_valid && bus.i_rd_ready;

    assign bus.o_ram_addr = addr;
    assign bus.o_ram_data = bus.i_wr_data;
    assign bus.o_rd_valid = rd_valid;
    assign bus.o_rd_data  = rd_data;
    assign bus.o_rd_last  = rd_last;
    assign bus.o_done     = done;

    // State register; reset aborts any burst immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state and state-decoded handshake / RAM strobes.
    always_comb begin
        state_nxt       = state;
        bus.o_cmd_ready = 1'b0;
        bus.o_busy      = 1'b1;
        bus.o_wr_ready  = 1'b0;
        bus.o_ram_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.o_cmd_ready = 1'b1;
                bus.o_busy      = 1'b0;
                if (bus.i_cmd_valid)
                    state_nxt = bus.i_cmd_write ? ST_WRITE : ST_READ;
            end
            ST_WRITE: begin
                bus.o_wr_ready = 1'b1;
                bus.o_ram_we   = bus.i_wr_valid;
                if (wr_accept && last_count)
                    state_nxt = ST_IDLE;
            end
            ST_READ: begin
                if (rd_take && rd_last)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address/count tracking, read output register and completion pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr          <= '0;
            remaining     <= '0;
            fetch_pending <= 1'b0;
            rd_valid      <= 1'b0;
            rd_last       <= 1'b0;
            rd_data       <= '0;
            done          <= 1'b0;
        end else begin
            done <= (wr_accept && last_count) || (rd_take && rd_last);

            if (cmd_accept) begin
                addr          <= bus.i_cmd_addr;
                remaining     <= bus.i_cmd_len;
                fetch_pending <= !bus.i_cmd_write;
            end else if (wr_accept || rd_load) begin
                // Address wraps naturally at 2^ADDR_WIDTH.
                addr      <= addr + ADDR_WIDTH'(1);
                remaining <= remaining - LEN_WIDTH'(1);
                if (rd_load && last_count)
                    fetch_pending <= 1'b0;
            end

            if (rd_load) begin
                rd_valid <= 1'b1;
                rd_data  <= bus.i_ram_data;
                rd_last  <= last_count;
            end else if (rd_take) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_dma.sv
// Self-checking bench for ram_burst_dma. Hosts a behavioural RAM, and keeps
// an independent reference memory that is updated only from the words the
// bench intends to commit.
module tb_ram_burst_dma;
    import ram_dma_pkg::*;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_burst_dma_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    ram_burst_dma #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Behavioural single-port RAM: synchronous write, combinational read.
    logic [DW-1:0] ram [0:65535];
    always @(posedge clk) if (bus.o_ram_we) ram[bus.o_ram_addr] <= bus.o_ram_data;
    assign bus.i_ram_data = ram[bus.o_ram_addr];

    logic [DW-1:0] ref_mem [0:65535];
    logic [DW-1:0] wq [$];

    int checks = 0;
    int errors = 0;

    task automatic issue_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
        @(negedge clk);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_write = wr;
        bus.i_cmd_addr  = a;
        bus.i_cmd_len   = l;
        #1;
        checks++;
        if (bus.o_cmd_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL cmd_accept_idle: cmd_ready=%b busy=%b, want 1/0", bus.o_cmd_ready, bus.o_busy);
        end
    endtask

    task automatic run_write(input logic [AW-1:0] a, input logic [LW-1:0] l,
                             input bit gaps, input bit hold_cmd);
        int k = 0;
        int cyc = 0;
        logic v;
        logic [AW-1:0] ea;
        issue_cmd(1'b1, a, l);
        while (k <= int'(l) && cyc < 2000) begin
            @(negedge clk);
            if (hold_cmd) begin
                bus.i_cmd_addr  = a ^ 16'h0800;
                bus.i_cmd_write = 1'b0;
            end else begin
                bus.i_cmd_valid = 1'b0;
            end
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.i_wr_valid = v;
            bus.i_wr_data  = v ? wq[k] : DW'($urandom);
            #1;
            checks++;
            if (bus.o_wr_ready !== 1'b1 || bus.o_cmd_ready !== 1'b0 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b1) begin
                errors++;
                $display("FAIL write_state: wr_ready=%b cmd_ready=%b done=%b busy=%b, want 1/0/0/1",
                         bus.o_wr_ready, bus.o_cmd_ready, bus.o_done, bus.o_busy);
            end
            checks++;
            if (bus.o_ram_we !== v) begin
                errors++;
                $display("FAIL write_we: we=%b want %b (beat %0d)", bus.o_ram_we, v, k);
            end
            if (v) begin
                ea = AW'(int'(a) + k);
                checks++;
                if (bus.o_ram_addr !== ea || bus.o_ram_data !== wq[k]) begin
                    errors++;
                    $display("FAIL write_beat: addr=%h data=%h want %h/%h", bus.o_ram_addr, bus.o_ram_data, ea, wq[k]);
                end
                ref_mem[ea] = wq[k];
                k++;
            end
            cyc++;
        end
        checks++;
        if (k <= int'(l)) begin
            errors++;
            $display("FAIL write_timeout: %0d beats accepted want %0d", k, int'(l) + 1);
        end
        @(negedge clk);
        bus.i_wr_valid  = 1'b0;
        bus.i_cmd_valid = 1'b0;
        #1;
        checks++;
        if (bus.o_done !== 1'b1 || bus.o_cmd_ready !== 1'b1 || bus.o_ram_we !== 1'b0) begin
            errors++;
            $display("FAIL write_done: done=%b cmd_ready=%b we=%b want 1/1/0", bus.o_done, bus.o_cmd_ready, bus.o_ram_we);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL write_done_pulse: done=%b busy=%b want 0/0", bus.o_done, bus.o_busy);
        end
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0 repeating; 2: random
    task automatic run_read(input logic [AW-1:0] a, input logic [LW-1:0] l, input int mode);
        int k = 0;
        int cyc = 0;
        int first = -1;
        logic r;
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [DW-1:0] pd = '0;
        logic [AW-1:0] ea;
        issue_cmd(1'b0, a, l);
        while (k <= int'(l) && cyc < 3000) begin
            @(negedge clk);
            bus.i_cmd_valid = 1'b0;
            r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            bus.i_rd_ready = r;
            #1;
            checks++;
            if (bus.o_ram_we !== 1'b0 || bus.o_done !== 1'b0 || bus.o_cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL read_state: we=%b done=%b cmd_ready=%b want 0/0/0", bus.o_ram_we, bus.o_done, bus.o_cmd_ready);
            end
            if (pv && !pr) begin
                checks++;
                if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== pd || bus.o_rd_last !== pl) begin
                    errors++;
                    $display("FAIL read_hold: valid=%b data=%h last=%b want 1/%h/%b", bus.o_rd_valid, bus.o_rd_data, bus.o_rd_last, pd, pl);
                end
            end
            if (bus.o_rd_valid === 1'b1) begin
                if (first < 0) first = cyc;
                checks++;
                if (bus.o_rd_last !== (k == int'(l))) begin
                    errors++;
                    $display("FAIL read_last: last=%b at word %0d of %0d", bus.o_rd_last, k, int'(l) + 1);
                end
                if (r) begin
                    ea = AW'(int'(a) + k);
                    checks++;
                    if (bus.o_rd_data !== ref_mem[ea]) begin
                        errors++;
                        $display("FAIL read_data: addr %h data=%h want %h", ea, bus.o_rd_data, ref_mem[ea]);
                    end
                    k++;
                end
            end
            pv = bus.o_rd_valid; pr = r; pd = bus.o_rd_data; pl = bus.o_rd_last;
            cyc++;
        end
        checks++;
        if (k <= int'(l)) begin
            errors++;
            $display("FAIL read_timeout: %0d words received want %0d", k, int'(l) + 1);
        end
        checks++;
        if (first != 1) begin
            errors++;
            $display("FAIL read_latency: first valid %0d cycles after accept want 2", first + 1);
        end
        if (mode == 0) begin
            checks++;
            if (cyc != int'(l) + 2) begin
                errors++;
                $display("FAIL read_throughput: %0d cycles want %0d", cyc, int'(l) + 2);
            end
        end
        @(negedge clk);
        bus.i_rd_ready = 1'b0;
        #1;
        checks++;
        if (bus.o_done !== 1'b1 || bus.o_rd_valid !== 1'b0 || bus.o_rd_last !== 1'b0 || bus.o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_done: done=%b valid=%b last=%b cmd_ready=%b want 1/0/0/1",
                     bus.o_done, bus.o_rd_valid, bus.o_rd_last, bus.o_cmd_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.o_done !== 1'b0) begin
            errors++;
            $display("FAIL read_done_pulse: done=%b want 0 (second pulse)", bus.o_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_cmd_valid = 1'b0; bus.i_cmd_write = 1'b0; bus.i_cmd_addr = '0; bus.i_cmd_len = '0;
        bus.i_wr_valid = 1'b0; bus.i_wr_data = '0; bus.i_rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.o_cmd_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_ram_we !== 1'b0 || bus.o_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: cmd_ready=%b busy=%b we=%b wr_ready=%b want 1/0/0/0",
                     bus.o_cmd_ready, bus.o_busy, bus.o_ram_we, bus.o_wr_ready);
        end
        checks++;
        if (bus.o_rd_valid !== 1'b0 || bus.o_rd_last !== 1'b0 || bus.o_rd_data !== '0 || bus.o_done !== 1'b0 || bus.o_ram_addr !== '0) begin
            errors++;
            $display("FAIL reset_regs: valid=%b last=%b data=%h done=%b addr=%h want all 0",
                     bus.o_rd_valid, bus.o_rd_last, bus.o_rd_data, bus.o_done, bus.o_ram_addr);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_basic();
        wq = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
        run_write(16'h0010, 8'd3, 1'b0, 1'b0);
    endtask

    task automatic test_read_basic();
        run_read(16'h0010, 8'd3, 0);
    endtask

    task automatic test_read_stall();
        run_read(16'h0010, 8'd3, 1);
    endtask

    task automatic test_wrap();
        wq = '{16'h1111, 16'h2222};
        run_write(16'hFFFF, 8'd1, 1'b0, 1'b0);
        checks++;
        if (ref_mem[16'h0000] !== 16'h2222 || ram[16'h0000] !== 16'h2222 || ram[16'hFFFF] !== 16'h1111) begin
            errors++;
            $display("FAIL wrap_ram: ram[FFFF]=%h ram[0000]=%h want 1111/2222", ram[16'hFFFF], ram[16'h0000]);
        end
        run_read(16'hFFFF, 8'd1, 0);
    endtask

    task automatic test_reset_midburst();
        logic [DW-1:0] nd [0:7];
        wq.delete();
        for (int i = 0; i < 8; i++) wq.push_back(16'h5000 + 16'(i));
        run_write(16'h0200, 8'd7, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) nd[i] = 16'hC000 + 16'(i);
        issue_cmd(1'b1, 16'h0200, 8'd7);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.i_cmd_valid = 1'b0;
            bus.i_wr_valid  = 1'b1;
            bus.i_wr_data   = nd[i];
            ref_mem[16'h0200 + 16'(i)] = nd[i];
        end
        @(negedge clk);
        bus.i_wr_data = nd[2];
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.o_ram_we !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_cmd_ready !== 1'b1 || bus.o_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: we=%b busy=%b cmd_ready=%b wr_ready=%b want 0/0/1/0",
                     bus.o_ram_we, bus.o_busy, bus.o_cmd_ready, bus.o_wr_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.i_wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done: done=%b busy=%b want 0/0", bus.o_done, bus.o_busy);
            end
        end
        run_read(16'h0200, 8'd7, 0);
    endtask

    task automatic test_cmd_hold();
        wq = '{16'h7A01, 16'h7A02, 16'h7A03, 16'h7A04, 16'h7A05};
        run_write(16'h0300, 8'd4, 1'b1, 1'b1);
        run_read(16'h0300, 8'd4, 2);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        logic [LW-1:0] l;
        for (int n = 0; n < 6; n++) begin
            a = AW'($urandom);
            l = LW'($urandom_range(0, 20));
            wq.delete();
            for (int i = 0; i <= int'(l); i++) wq.push_back(DW'($urandom));
            run_write(a, l, 1'b1, 1'b0);
            run_read(a, l, 2);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_read_stall();
        test_wrap();
        test_reset_midburst();
        test_cmd_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
